// File: rtl/breakout_pkg.sv
// breakout_pkg: playfield geometry and state encodings shared by the game controller and the renderer.
package breakout_pkg;
    typedef logic signed [10:0] coord_t;
    localparam coord_t WALL_L      = 11'sd8;
    localparam coord_t WALL_R      = 11'sd784;
    localparam coord_t CEILING     = 11'sd80;
    localparam coord_t PADDLE_ROW  = 11'sd576;
    localparam coord_t LOSS_LINE   = 11'sd600;
    localparam coord_t PADDLE_LEN  = 11'sd60;
    localparam coord_t BALL_SIZE   = 11'sd8;
    localparam coord_t PADDLE_MIN  = 11'sd8;
    localparam coord_t PADDLE_MAX  = 11'sd732;
    localparam coord_t PADDLE_HOME = 11'sd370;
    localparam coord_t BALL_OFS    = 11'sd26;
    localparam coord_t PARK_Y      = 11'sd1016;
    typedef enum logic [2:0] {SEQ_IDLE, SEQ_PADDLE, SEQ_BALL_X, SEQ_BALL_Y, SEQ_COMMIT} seq_e;
    typedef enum logic [1:0] {GS_SERVE, GS_PLAY, GS_OVER} game_e;
    function automatic coord_t sx(input logic [9:0] v);
        return coord_t'({1'b0, v});
    endfunction
endpackage

// File: rtl/breakout_game_controller_if.sv
// breakout_game_controller_if: renderer/button side of the game controller.
interface breakout_game_controller_if;
    logic       frame_done;
    logic       btn_left;
    logic       btn_right;
    logic       btn_serve;
    logic [9:0] paddle_x_pixel;
    logic [9:0] ball_x_pixel;
    logic [9:0] ball_y_pixel;
    logic [1:0] lives;
    logic       game_over;
    logic       update_done;
    modport master (
        output frame_done, btn_left, btn_right, btn_serve,
        input  paddle_x_pixel, ball_x_pixel, ball_y_pixel, lives, game_over, update_done
    );
    modport slave (
        input  frame_done, btn_left, btn_right, btn_serve,
        output paddle_x_pixel, ball_x_pixel, ball_y_pixel, lives, game_over, update_done
    );
endinterface

// File: rtl/breakout_game_controller_button_sync.sv
// button_sync: two-flop synchronizer for asynchronous button levels.
module button_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1_q, s2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end
    assign q = s2_q;
endmodule

// File: rtl/breakout_game_controller.sv
// breakout_game_controller: per-frame paddle/ball/lives update, committed to the renderer in one step.
module breakout_game_controller
    import breakout_pkg::*;
#(
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SPEED   = 2,
    parameter int START_LIVES  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    breakout_game_controller_if.slave  bus
);
    localparam coord_t     PS     = coord_t'(PADDLE_SPEED);
    localparam coord_t     BS     = coord_t'(BALL_SPEED);
    localparam logic [1:0] LIVES0 = 2'(START_LIVES);

    seq_e       seq_q, seq_d;
    game_e      gs_q, gs_d;
    logic [2:0] btn_s, btn_q, btn_d;
    logic [9:0] pad_q, pad_d, bx_q, bx_d, by_q, by_d;
    logic       dx_q, dx_d, up_q, up_d;
    logic [1:0] lives_q, lives_d;
    logic [9:0] opad_q, opad_d, obx_q, obx_d, oby_q, oby_d;
    logic [1:0] olives_q, olives_d;
    logic       oover_q, oover_d, upd_q, upd_d;
    coord_t     p_mv, p_cl, nx, ny;
    logic       hit, x_flip;

    button_sync #(.W(3)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({bus.btn_serve, bus.btn_right, bus.btn_left}),
        .q     (btn_s)
    );

    // btn_q = {serve, right, left} as sampled for this update
    assign p_mv   = (btn_q[1] & ~btn_q[0]) ? sx(pad_q) + PS :
                    (btn_q[0] & ~btn_q[1]) ? sx(pad_q) - PS : sx(pad_q);
    assign p_cl   = p_mv > PADDLE_MAX ? PADDLE_MAX : p_mv < PADDLE_MIN ? PADDLE_MIN : p_mv;
    assign nx     = dx_q ? sx(bx_q) + BS : sx(bx_q) - BS;
    assign ny     = up_q ? sx(by_q) - BS : sx(by_q) + BS;
    assign x_flip = dx_q ? nx >= WALL_R : nx <= WALL_L;
    assign hit    = (sx(bx_q) + BALL_SIZE > sx(pad_q)) && (sx(bx_q) < sx(pad_q) + PADDLE_LEN);

    always_comb begin
        seq_d    = seq_q;
        gs_d     = gs_q;
        btn_d    = btn_q;
        pad_d    = pad_q;
        bx_d     = bx_q;
        by_d     = by_q;
        dx_d     = dx_q;
        up_d     = up_q;
        lives_d  = lives_q;
        opad_d   = opad_q;
        obx_d    = obx_q;
        oby_d    = oby_q;
        olives_d = olives_q;
        oover_d  = oover_q;
        upd_d    = 1'b0;
        case (seq_q)
            SEQ_IDLE: begin
                if (bus.frame_done) begin
                    seq_d = SEQ_PADDLE;
                    btn_d = btn_s;
                end
            end
            SEQ_PADDLE: begin
                seq_d = SEQ_BALL_X;
                pad_d = 10'(p_cl);
                if (gs_q == GS_OVER) begin
                    bx_d = '0;
                    by_d = 10'(PARK_Y);
                    if (btn_q[2]) begin
                        gs_d    = GS_SERVE;
                        lives_d = LIVES0;
                        pad_d   = 10'(PADDLE_HOME);
                        bx_d    = 10'(PADDLE_HOME + BALL_OFS);
                        by_d    = 10'(PADDLE_ROW);
                    end
                end else if (gs_q == GS_SERVE) begin
                    bx_d = 10'(p_cl + BALL_OFS);
                    by_d = 10'(PADDLE_ROW);
                    if (btn_q[2]) begin
                        gs_d = GS_PLAY;
                        dx_d = 1'b1;
                        up_d = 1'b1;
                    end
                end
            end
            SEQ_BALL_X: begin
                seq_d = SEQ_BALL_Y;
                if (gs_q == GS_PLAY) begin
                    bx_d = !x_flip ? 10'(nx) : dx_q ? 10'(WALL_R) : 10'(WALL_L);
                    dx_d = dx_q ^ x_flip;
                end
            end
            SEQ_BALL_Y: begin
                seq_d = SEQ_COMMIT;
                if (gs_q == GS_PLAY) begin
                    if (up_q) begin
                        by_d = ny <= CEILING ? 10'(CEILING) : 10'(ny);
                        up_d = ny > CEILING;
                    end else if (ny >= PADDLE_ROW && sx(by_q) < PADDLE_ROW && hit) begin
                        by_d = 10'(PADDLE_ROW);
                        up_d = 1'b1;
                    end else if (ny >= LOSS_LINE) begin
                        lives_d = lives_q - 2'd1;
                        gs_d    = lives_q > 2'd1 ? GS_SERVE : GS_OVER;
                        bx_d    = lives_q > 2'd1 ? 10'(sx(pad_q) + BALL_OFS) : '0;
                        by_d    = lives_q > 2'd1 ? 10'(PADDLE_ROW) : 10'(PARK_Y);
                        dx_d    = 1'b1;
                        up_d    = 1'b1;
                    end else begin
                        by_d = 10'(ny);
                    end
                end
            end
            SEQ_COMMIT: begin
                seq_d    = SEQ_IDLE;
                opad_d   = pad_q;
                obx_d    = bx_q;
                oby_d    = by_q;
                olives_d = lives_q;
                oover_d  = gs_q == GS_OVER;
                upd_d    = 1'b1;
            end
            default: seq_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q    <= SEQ_IDLE;
            gs_q     <= GS_SERVE;
            btn_q    <= '0;
            pad_q    <= 10'(PADDLE_HOME);
            bx_q     <= 10'(PADDLE_HOME + BALL_OFS);
            by_q     <= 10'(PADDLE_ROW);
            dx_q     <= 1'b1;
            up_q     <= 1'b1;
            lives_q  <= LIVES0;
            opad_q   <= 10'(PADDLE_HOME);
            obx_q    <= 10'(PADDLE_HOME + BALL_OFS);
            oby_q    <= 10'(PADDLE_ROW);
            olives_q <= LIVES0;
            oover_q  <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            seq_q    <= seq_d;
            gs_q     <= gs_d;
            btn_q    <= btn_d;
            pad_q    <= pad_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            dx_q     <= dx_d;
            up_q     <= up_d;
            lives_q  <= lives_d;
            opad_q   <= opad_d;
            obx_q    <= obx_d;
            oby_q    <= oby_d;
            olives_q <= olives_d;
            oover_q  <= oover_d;
            upd_q    <= upd_d;
        end
    end

    assign bus.paddle_x_pixel = opad_q;
    assign bus.ball_x_pixel   = obx_q;
    assign bus.ball_y_pixel   = oby_q;
    assign bus.lives          = olives_q;
    assign bus.game_over      = oover_q;
    assign bus.update_done    = upd_q;
endmodule

// File: tb/tb_breakout_game_controller.sv
// tb_breakout_game_controller: randomized and directed frames checked every cycle against a per-frame game model.
module tb_breakout_game_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    breakout_game_controller_if bus ();
    breakout_game_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0, failures = 0, cyc = 0, upd_cnt = 0;
    bit chk_en = 0, pend = 0;
    int pend_cyc = 0;
    int m_pad, m_bx, m_by, m_dx, m_dy, m_lives, m_gs;
    int e_pad, e_bx, e_by, e_lives, e_over, e_upd;
    int p_pad, p_bx, p_by, p_lives, p_over;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.update_done === 1'b1) upd_cnt <= upd_cnt + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", n, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pad = 370; m_bx = 396; m_by = 576; m_dx = 1; m_dy = -1; m_lives = 3; m_gs = 0;
        e_pad = 370; e_bx = 396; e_by = 576; e_lives = 3; e_over = 0; e_upd = 0;
        pend = 0;
    endfunction

    // game states: 0 serve, 1 play, 2 over
    function automatic void model_update(input bit l, input bit r, input bit s);
        int nx, ny;
        if (r && !l) m_pad = (m_pad + 4 > 732) ? 732 : m_pad + 4;
        else if (l && !r) m_pad = (m_pad - 4 < 8) ? 8 : m_pad - 4;
        if (m_gs == 2 && s) begin
            m_gs = 0; m_lives = 3; m_pad = 370;
        end else if (m_gs == 0 && s) begin
            m_gs = 1; m_dx = 1; m_dy = -1; m_bx = m_pad + 26; m_by = 576;
        end
        if (m_gs == 1) begin
            nx = m_bx + 2 * m_dx;
            if (m_dx > 0 && nx >= 784) begin m_bx = 784; m_dx = -1; end
            else if (m_dx < 0 && nx <= 8) begin m_bx = 8; m_dx = 1; end
            else m_bx = nx;
            ny = m_by + 2 * m_dy;
            if (m_dy < 0) begin
                if (ny <= 80) begin m_by = 80; m_dy = 1; end
                else m_by = ny;
            end else if (ny >= 576 && m_by < 576 && m_bx + 8 > m_pad && m_bx < m_pad + 60) begin
                m_by = 576; m_dy = -1;
            end else if (ny >= 600) begin
                m_lives--;
                m_gs = (m_lives == 0) ? 2 : 0;
                m_dx = 1; m_dy = -1;
            end else m_by = ny;
        end
        if (m_gs == 0) begin m_bx = m_pad + 26; m_by = 576; end
        if (m_gs == 2) begin m_bx = 0; m_by = 1016; end
    endfunction

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            if (pend && cyc == pend_cyc) begin
                e_pad = p_pad; e_bx = p_bx; e_by = p_by; e_lives = p_lives; e_over = p_over;
                pend = 0; e_upd = 1;
            end else e_upd = 0;
            chk("paddle_x", 32'(bus.paddle_x_pixel), e_pad);
            chk("ball_x", 32'(bus.ball_x_pixel), e_bx);
            chk("ball_y", 32'(bus.ball_y_pixel), e_by);
            chk("lives", 32'(bus.lives), e_lives);
            chk("game_over", 32'(bus.game_over), e_over);
            chk("update_done", 32'(bus.update_done), e_upd);
        end
    end

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1;
    endtask

    task automatic frame(input bit l, input bit r, input bit s, input bit dbl);
        @(negedge clk); #1;
        bus.btn_left = l; bus.btn_right = r; bus.btn_serve = s;
        repeat (3) @(negedge clk);
        #1;
        model_update(l, r, s);
        p_pad = m_pad; p_bx = m_bx; p_by = m_by; p_lives = m_lives; p_over = (m_gs == 2);
        pend_cyc = cyc + 5;
        pend = 1;
        bus.frame_done = 1'b1;
        @(negedge clk); #1 bus.frame_done = 1'b0;
        if (dbl) begin
            @(negedge clk); #1 bus.frame_done = 1'b1;
            @(negedge clk); #1 bus.frame_done = 1'b0;
            repeat (3) @(negedge clk);
        end else repeat (5) @(negedge clk);
    endtask

    initial begin
        int c;
        bus.frame_done = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_serve = 1'b0;
        do_reset();
        chk("rst_paddle", 32'(bus.paddle_x_pixel), 370);
        chk("rst_ball_x", 32'(bus.ball_x_pixel), 396);
        chk("rst_ball_y", 32'(bus.ball_y_pixel), 576);
        chk("rst_lives", 32'(bus.lives), 3);
        chk("rst_over", 32'(bus.game_over), 0);
        chk("rst_upd", 32'(bus.update_done), 0);

        for (int i = 1; i <= 100; i++) begin
            frame(0, 1, 0, 0);
            if (i == 1) chk("right_step", 32'(bus.paddle_x_pixel), 374);
            if (i == 91) chk("right_sat", 32'(bus.paddle_x_pixel), 732);
        end
        chk("track_x", 32'(bus.ball_x_pixel), 758);
        chk("track_y", 32'(bus.ball_y_pixel), 576);

        c = upd_cnt;
        frame(0, 0, 0, 1);
        chk("dbl_pulse_count", 32'(upd_cnt - c), 1);

        do_reset();
        for (int k = 1; k <= 500; k++) begin
            frame(k >= 2 && k <= 56, 0, k == 1, 0);
            if (k == 1) begin
                chk("serve_x", 32'(bus.ball_x_pixel), 398);
                chk("serve_y", 32'(bus.ball_y_pixel), 574);
            end
            if (k == 194) chk("wall_x", 32'(bus.ball_x_pixel), 784);
            if (k == 195) chk("wall_back_x", 32'(bus.ball_x_pixel), 782);
            if (k == 248) chk("ceiling_y", 32'(bus.ball_y_pixel), 80);
            if (k == 249) chk("ceiling_back_y", 32'(bus.ball_y_pixel), 82);
            if (k == 496) chk("paddle_bounce_y", 32'(bus.ball_y_pixel), 576);
            if (k == 497) begin
                chk("after_bounce_y", 32'(bus.ball_y_pixel), 574);
                chk("bounce_lives", 32'(bus.lives), 3);
            end
        end

        do_reset();
        for (int m = 1; m <= 3; m++) begin
            for (int k = 1; k <= 508; k++) frame(0, 0, k == 1, 0);
            if (m < 3) begin
                chk("miss_lives", 32'(bus.lives), 32'(3 - m));
                chk("miss_ball_x", 32'(bus.ball_x_pixel), 396);
                chk("miss_ball_y", 32'(bus.ball_y_pixel), 576);
            end
        end
        chk("over_flag", 32'(bus.game_over), 1);
        chk("over_lives", 32'(bus.lives), 0);
        chk("over_ball_y", 32'(bus.ball_y_pixel), 1016);
        chk("over_ball_x", 32'(bus.ball_x_pixel), 0);
        frame(0, 0, 1, 0);
        chk("restart_lives", 32'(bus.lives), 3);
        chk("restart_paddle", 32'(bus.paddle_x_pixel), 370);
        chk("restart_over", 32'(bus.game_over), 0);
        chk("restart_ball_y", 32'(bus.ball_y_pixel), 576);

        for (int i = 0; i < 1200; i++) begin
            frame($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        c = upd_cnt;
        @(negedge clk); #1 bus.frame_done = 1'b1;
        @(negedge clk); #1 bus.frame_done = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("abort_no_commit", 32'(upd_cnt - c), 0);
        chk("abort_paddle", 32'(bus.paddle_x_pixel), 370);
        chk("abort_ball_x", 32'(bus.ball_x_pixel), 396);
        chk("abort_ball_y", 32'(bus.ball_y_pixel), 576);
        chk("abort_lives", 32'(bus.lives), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
